// File: rtl/morse_input_scheduler.sv
// morse_input_scheduler
//   Front-end key scheduler for the Morse translator datapath. Each of the
//   six raw keys is synchronised (2 flops), debounced, edge-detected and
//   latched into a one-deep pending bit. A fixed-priority arbiter grants one
//   pending key at a time and the FSM drives a clean PULSE_CYCLES-wide
//   one-hot pulse followed by a GAP_CYCLES quiet gap, so the slow (divide-by-10)
//   consumer can sample every event.
//
//   Optional feature: define MORSE_EVENT_COUNT_EN to build a 16-bit wrapping
//   counter of granted events on event_count; otherwise event_count is 0.
//
// Ports
//   clk                    system clock
//   Reset_n                asynchronous active-low reset
//   Dot_in .. Enter_in     raw asynchronous key levels (1 = pressed)
//   Dot .. Enter           scheduled one-hot pulses (at most one high)
//   busy                   FSM is in ISSUE or GAP
//   overrun                1-cycle pulse when a key edge is dropped
//   event_count            granted-event count (0 when feature disabled)
module morse_input_scheduler #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PULSE_CYCLES    = 10,
  parameter int GAP_CYCLES      = 10
) (
  input  logic        clk,
  input  logic        Reset_n,
  input  logic        Dot_in,
  input  logic        Dash_in,
  input  logic        Space_in,
  input  logic        EndSeq_in,
  input  logic        Clear_in,
  input  logic        Enter_in,
  output logic        Dot,
  output logic        Dash,
  output logic        Space,
  output logic        EndSeq,
  output logic        Clear,
  output logic        Enter,
  output logic        busy,
  output logic        overrun,
  output logic [15:0] event_count
);

  localparam int NK      = 6;
  localparam int K_DOT   = 0;
  localparam int K_DASH  = 1;
  localparam int K_SPACE = 2;
  localparam int K_ENDSQ = 3;
  localparam int K_CLEAR = 4;
  localparam int K_ENTER = 5;

  localparam int CW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TMAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  // Counter value on the last mismatching cycle before the level flips.
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  logic [NK-1:0] keys_raw;
  logic [NK-1:0] sync1_q, sync2_q;
  logic [NK-1:0] deb_q, deb_prev_q;
  logic [CW-1:0] cnt_q [NK];
  logic [NK-1:0] pend_q, pend_d;
  logic [NK-1:0] rise;
  logic [NK-1:0] grant;
  logic [NK-1:0] clr_mask;
  logic          take;
  logic          overrun_q, overrun_d;

  state_t        state_q;
  logic [TW-1:0] timer_q;
  logic [NK-1:0] sel_q;
  logic [NK-1:0] out_q;

  assign keys_raw = {Enter_in, Clear_in, EndSeq_in, Space_in, Dash_in, Dot_in};

  // ---- synchroniser stage ----
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= keys_raw;
      sync2_q <= sync1_q;
    end
  end

  // ---- debounce stage ----
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      deb_q      <= '0;
      deb_prev_q <= '0;
      for (int i = 0; i < NK; i++) cnt_q[i] <= '0;
    end else begin
      deb_prev_q <= deb_q;
      for (int i = 0; i < NK; i++) begin
        if (sync2_q[i] == deb_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == DEB_LAST) begin
          deb_q[i] <= ~deb_q[i];
          cnt_q[i] <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // ---- edge detect, arbitration and pending stage ----
  assign rise = deb_q & ~deb_prev_q;

  always_comb begin
    grant = '0;
    if (state_q == S_IDLE) begin
      if      (pend_q[K_CLEAR]) grant[K_CLEAR] = 1'b1;
      else if (pend_q[K_ENTER]) grant[K_ENTER] = 1'b1;
      else if (pend_q[K_ENDSQ]) grant[K_ENDSQ] = 1'b1;
      else if (pend_q[K_SPACE]) grant[K_SPACE] = 1'b1;
      else if (pend_q[K_DASH])  grant[K_DASH]  = 1'b1;
      else if (pend_q[K_DOT])   grant[K_DOT]   = 1'b1;
    end
  end

  assign take = |grant;

  // A Clear grant discards everything else that was waiting.
  assign clr_mask = grant[K_CLEAR] ? {NK{1'b1}} : grant;

  // New edges land after the grant/flush, so a key re-pressed while being
  // served (or while being flushed) is simply pending again, not an overrun.
  assign pend_d    = (pend_q & ~clr_mask) | rise;
  assign overrun_d = |(rise & pend_q & ~clr_mask);

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pend_q    <= '0;
      overrun_q <= 1'b0;
    end else begin
      pend_q    <= pend_d;
      overrun_q <= overrun_d;
    end
  end

  // ---- pulse FSM stage ----
  // The output register lags the state by one cycle: ISSUE lasts exactly
  // PULSE_CYCLES cycles and the pulse covers the same count one cycle later.
  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      sel_q   <= '0;
      out_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          out_q <= '0;
          if (take) begin
            sel_q   <= grant;
            timer_q <= TW'(PULSE_CYCLES);
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          out_q <= sel_q;
          if (timer_q == TW'(1)) begin
            timer_q <= TW'(GAP_CYCLES);
            state_q <= S_GAP;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        S_GAP: begin
          out_q <= '0;
          if (timer_q == TW'(1)) begin
            state_q <= S_IDLE;
          end else begin
            timer_q <= timer_q - 1'b1;
          end
        end
        default: begin
          out_q   <= '0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign Dot     = out_q[K_DOT];
  assign Dash    = out_q[K_DASH];
  assign Space   = out_q[K_SPACE];
  assign EndSeq  = out_q[K_ENDSQ];
  assign Clear   = out_q[K_CLEAR];
  assign Enter   = out_q[K_ENTER];
  assign busy    = (state_q != S_IDLE);
  assign overrun = overrun_q;

  // ---- optional event counter ----
`ifdef MORSE_EVENT_COUNT_EN
  logic [15:0] event_cnt_q;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      event_cnt_q <= 16'h0000;
    end else if (take) begin
      event_cnt_q <= event_cnt_q + 16'd1;
    end
  end

  assign event_count = event_cnt_q;
`else
  assign event_count = 16'h0000;
`endif

endmodule

// File: tb/tb_morse_input_scheduler.sv
module tb_morse_input_scheduler;

  localparam int DEB  = 16;
  localparam int PUL  = 10;
  localparam int GAP  = 10;
  localparam int LAT  = DEB + 5;          // drive point (after edge n) to first high sample
  localparam int SPC  = PUL + GAP + 1;    // rising-edge spacing of back-to-back events
  localparam int NV   = 9;

  logic clk = 1'b0;
  logic Reset_n = 1'b0;
  logic Dot_in = 0, Dash_in = 0, Space_in = 0, EndSeq_in = 0, Clear_in = 0, Enter_in = 0;
  logic Dot, Dash, Space, EndSeq, Clear, Enter, busy, overrun;
  logic [15:0] event_count;

  morse_input_scheduler #(
    .DEBOUNCE_CYCLES(DEB),
    .PULSE_CYCLES   (PUL),
    .GAP_CYCLES     (GAP)
  ) dut (
    .clk        (clk),
    .Reset_n    (Reset_n),
    .Dot_in     (Dot_in),
    .Dash_in    (Dash_in),
    .Space_in   (Space_in),
    .EndSeq_in  (EndSeq_in),
    .Clear_in   (Clear_in),
    .Enter_in   (Enter_in),
    .Dot        (Dot),
    .Dash       (Dash),
    .Space      (Space),
    .EndSeq     (EndSeq),
    .Clear      (Clear),
    .Enter      (Enter),
    .busy       (busy),
    .overrun    (overrun),
    .event_count(event_count)
  );

  always #5 clk = ~clk;

  // ---- event monitor (samples on the falling edge) ----
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [5:0] outs;
  logic [5:0] prev_outs = '0;
  assign outs = {Enter, Clear, EndSeq, Space, Dash, Dot};

  int ev_key[$];
  int ev_cyc[$];
  int ev_w[$];
  int last_rise = 0;
  int busy_cnt = 0;
  int ovr_cnt = 0;
  bit multi_hot = 1'b0;

  always @(negedge clk) begin
    if (!$onehot0(outs)) multi_hot <= 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (outs[i] && !prev_outs[i]) begin
        ev_key.push_back(i);
        ev_cyc.push_back(cyc);
        last_rise <= cyc;
      end
    end
    if (prev_outs != 6'b0 && outs == 6'b0) ev_w.push_back(cyc - last_rise);
    busy_cnt  <= busy_cnt + int'(busy);
    ovr_cnt   <= ovr_cnt + int'(overrun);
    prev_outs <= outs;
  end

  // ---- checking helpers ----
  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_keys(input logic [5:0] m);
    {Enter_in, Clear_in, EndSeq_in, Space_in, Dash_in, Dot_in} = m;
  endtask

  task automatic add_events(input int n);
`ifdef MORSE_EVENT_COUNT_EN
    exp_cnt = exp_cnt + n;
`else
    exp_cnt = exp_cnt + 0 * n;
`endif
  endtask

  // Check n events since base indices against expected keys and timing.
  task automatic check_events(input string tag, input int eb, input int wb,
                              input int t_ref, input int n, input int ek[5]);
    check({tag, " count"}, ev_key.size() - eb, n);
    for (int i = 0; i < n; i++) begin
      if (eb + i < ev_key.size()) begin
        check($sformatf("%s key%0d", tag, i), ev_key[eb + i], ek[i]);
        check($sformatf("%s rise%0d", tag, i), ev_cyc[eb + i] - t_ref, LAT + SPC * i);
      end
      if (wb + i < ev_w.size())
        check($sformatf("%s width%0d", tag, i), ev_w[wb + i], PUL);
    end
  endtask

  typedef struct packed {
    logic [5:0] mask;   // {Enter,Clear,EndSeq,Space,Dash,Dot}
    int         hold;
    int         n_ev;
    int         k0;
    int         k1;
    int         k2;
  } vec_t;

  vec_t vecs [NV];

  initial begin
    int eb, wb, bb, ob, t_ref;
    int ek[5];

    // key indices: Dot0 Dash1 Space2 EndSeq3 Clear4 Enter5
    vecs[0] = '{6'b000001, 40, 1, 0, 0, 0};   // Dot alone
    vecs[1] = '{6'b001101, 40, 3, 3, 2, 0};   // Dot+Space+EndSeq -> EndSeq,Space,Dot
    vecs[2] = '{6'b010010, 40, 1, 4, 0, 0};   // Dash+Clear -> Clear flushes Dash
    vecs[3] = '{6'b100010, 40, 2, 5, 1, 0};   // Enter+Dash -> Enter does not flush
    vecs[4] = '{6'b111111, 40, 1, 4, 0, 0};   // all keys -> Clear only
    vecs[5] = '{6'b000001, 10, 0, 0, 0, 0};   // 10-cycle glitch rejected
    vecs[6] = '{6'b000100, 15, 0, 0, 0, 0};   // one short of debounce
    vecs[7] = '{6'b000100, 16, 1, 2, 0, 0};   // exactly debounce length
    vecs[8] = '{6'b001000, 40, 1, 3, 0, 0};   // EndSeq alone

    // ---- reset state ----
    tick(3);
    check("rst outs", int'(outs), 0);
    check("rst busy", int'(busy), 0);
    check("rst overrun", int'(overrun), 0);
    check("rst event_count", int'(event_count), 0);
    Reset_n = 1'b1;
    tick(5);
    check("post-rst outs", int'(outs), 0);

    // ---- table-driven vectors ----
    for (int v = 0; v < NV; v++) begin
      eb = ev_key.size(); wb = ev_w.size(); bb = busy_cnt; ob = ovr_cnt; t_ref = cyc;
      set_keys(vecs[v].mask);
      tick(vecs[v].hold);
      set_keys(6'b0);
      tick(160 - vecs[v].hold);
      ek = '{vecs[v].k0, vecs[v].k1, vecs[v].k2, 0, 0};
      check_events($sformatf("vec%0d", v), eb, wb, t_ref, vecs[v].n_ev, ek);
      check($sformatf("vec%0d busy", v), busy_cnt - bb, (PUL + GAP) * vecs[v].n_ev);
      check($sformatf("vec%0d overrun", v), ovr_cnt - ob, 0);
      add_events(vecs[v].n_ev);
      check($sformatf("vec%0d event_count", v), int'(event_count), exp_cnt);
    end

    // ---- overrun while the scheduler stays busy ----
    eb = ev_key.size(); wb = ev_w.size(); ob = ovr_cnt; t_ref = cyc;
    Dash_in = 1'b1;
    tick(5);
    Enter_in = 1'b1; EndSeq_in = 1'b1; Space_in = 1'b1;
    tick(15);
    Dot_in = 1'b1;                  // first clean press, Dash in ISSUE
    tick(20);
    Dot_in = 1'b0;
    set_keys(6'b0);
    tick(20);
    Dot_in = 1'b1;                  // second press while Dot still pending
    tick(20);
    Dot_in = 1'b0;
    tick(100);
    ek = '{1, 5, 3, 2, 0};
    check_events("ovr", eb, wb, t_ref, 5, ek);
    check("ovr overrun pulses", ovr_cnt - ob, 1);
    add_events(5);
    check("ovr event_count", int'(event_count), exp_cnt);

    // ---- reset in the middle of an Enter pulse ----
    t_ref = cyc;
    Enter_in = 1'b1;
    tick(LAT + 4);
    check("mid Enter high", int'(Enter), 1);
    Reset_n = 1'b0;
    #1;
    check("mid-rst outs", int'(outs), 0);
    check("mid-rst busy", int'(busy), 0);
    check("mid-rst event_count", int'(event_count), 0);
    exp_cnt = 0;
    tick(3);
    Reset_n = 1'b1;
    eb = ev_key.size(); wb = ev_w.size(); t_ref = cyc;
    tick(60);
    Enter_in = 1'b0;
    tick(40);
    ek = '{5, 0, 0, 0, 0};
    check_events("rst-enter", eb, wb, t_ref, 1, ek);
    add_events(1);
    check("rst-enter event_count", int'(event_count), exp_cnt);

    check("one-hot outputs", int'(multi_hot), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
